pt_check: RTL and testbench
===========================

Name: pt_check

Overview:
- Sits directly downstream of the ARC4 decrypt core and snoops its plaintext-memory write port (pt_addr/pt_wrdata/pt_wren).
- Validates the length-prefixed plaintext on the fly: addr 0 = length L, addr 1..L = characters, each of which must lie in a printable range.
- On the first bad byte it pulses halt back into the decrypt core, so the key search abandons a wrong key early.
- Reports a sticky pass/fail verdict per key attempt to the crack controller.

Parameters:
- CH_LO, 8'h20, lowest legal plaintext byte (inclusive)
- CH_HI, 8'h7E, highest legal plaintext byte (inclusive)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse: a new key attempt begins (controller asserts it in the same cycle it asserts decrypt en)
- pt_addr  in  8  snooped plaintext write address
- pt_wrdata  in  8  snooped plaintext write data
- pt_wren  in  1  snooped plaintext write enable
- halt  out  1  one-cycle abort pulse to the decrypt core
- busy  out  1  check in progress
- pass  out  1  sticky: all L bytes legal
- fail  out  1  sticky: illegal byte or protocol error
- proto_err  out  1  sticky: fail was caused by an out-of-order address, not bad data
- bad_addr  out  8  address of the offending write (valid while fail)
- bad_byte  out  8  data of the offending write (valid while fail)

Behaviour:
- Reset: state IDLE; all outputs 0; length/expected-address registers 0.
- States: IDLE, LEN, CHECK, PASS, FAIL. busy = (LEN or CHECK).
- start in any state, including mid-check: clear pass/fail/proto_err/bad_*, go to LEN next cycle. start has priority over any write in the same cycle; that write is ignored.
- Writes with pt_wren=0 are ignored. In IDLE/PASS/FAIL, all writes are ignored.
- LEN, write to addr 0:
  - Capture L = pt_wrdata; expected address = 1.
  - If L = 0, go to PASS; otherwise go to CHECK.
- LEN, write to addr ≠ 0: go to FAIL, proto_err=1, bad_addr/bad_byte = that write.
- CHECK, write with pt_addr = expected and CH_LO ≤ pt_wrdata ≤ CH_HI (unsigned compare):
  - If expected = L, go to PASS; otherwise expected += 1.
- CHECK, write with pt_addr = expected and byte out of range: go to FAIL, capture bad_addr/bad_byte.
- CHECK, write with pt_addr ≠ expected (skip or repeat): go to FAIL, proto_err=1.
- Entering FAIL: halt=1 for exactly the next cycle (registered, 1-cycle latency after the offending write), then 0. halt never asserts on PASS or in IDLE.
- L = 255: expected runs 1..255 in 8 bits with no wrap; PASS on the addr-255 write.
- pass and fail are never 1 simultaneously and hold until the next start or rst.
- The verdict appears the cycle after the deciding write.
- rst mid-check: immediate return to IDLE; no halt pulse.

Optional Feature:
- Macro PT_CHECK_STATS_EN.
- Defined:
  - Adds outputs attempts[15:0] (increments on each start) and passes[15:0] (increments on entry to PASS).
  - Both counters saturate at 16'hFFFF and clear on rst only.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package arc4_pkg:
  - state enum pt_check_state_t
  - constants PT_LEN_ADDR = 8'd0, DEF_CH_LO, DEF_CH_HI
- One natural sub-module, pt_range_cmp: combinational in-range compare, reused by the controller's key filter.
- The FSM and capture registers stay in pt_check.

Test Plan:
- start; writes addr0=3, addr1=8'h48, addr2=8'h69, addr3=8'h21 -> pass=1 one cycle after the addr3 write; fail=0; halt never asserted.
- start; addr0=4, addr1=8'h41, addr2=8'h07 -> fail=1, bad_addr=2, bad_byte=8'h07, proto_err=0; halt high exactly one cycle; a later addr3 write is ignored.
- start; addr0=0 -> pass=1 immediately after; busy=0.
- start; addr0=5, addr1=8'h41, addr3=8'h41 -> fail=1, proto_err=1, bad_addr=3.
- Mid-check (after addr0=9, addr1=8'h41), start pulses alongside an addr2 write -> flags cleared, state LEN, that write ignored; a following addr0=1, addr1=8'h7E -> pass=1. Repeat with CH_HI=8'h7D -> fail on 8'h7E.
- PT_CHECK_STATS_EN: 3 starts with 2 passing runs -> attempts=3, passes=2; rst -> both 0.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 cracking datapath: plaintext checker
// FSM states, the length-prefix address and the default printable range.
package arc4_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        CHECK = 3'd2,
        PASS  = 3'd3,
        FAIL  = 3'd4
    } pt_check_state_t;

    localparam logic [7:0] PT_LEN_ADDR = 8'd0;
    localparam logic [7:0] DEF_CH_LO   = 8'h20;
    localparam logic [7:0] DEF_CH_HI   = 8'h7E;

    // Saturating 16-bit increment for the attempt/pass statistics.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pt_range_cmp.sv
// Combinational inclusive range compare on one plaintext byte; shared with the
// controller's key filter.
module pt_range_cmp #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic [7:0] data,
    output logic       in_range
);

    assign in_range = (data >= LO) && (data <= HI);

endmodule

// File: rtl/pt_check.sv
// Snoops the ARC4 plaintext write port, validates the length-prefixed text and
// halts the decrypt core on the first bad write. Optional macro: PT_CHECK_STATS_EN.
module pt_check
    import arc4_pkg::*;
#(
    parameter logic [7:0] CH_LO = DEF_CH_LO,
    parameter logic [7:0] CH_HI = DEF_CH_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pt_addr,
    input  logic [7:0]  pt_wrdata,
    input  logic        pt_wren,
    output logic        halt,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic        proto_err,
    output logic [7:0]  bad_addr,
`ifdef PT_CHECK_STATS_EN
    output logic [15:0] attempts,
    output logic [15:0] passes,
`endif
    output logic [7:0]  bad_byte
);

    pt_check_state_t state_r, state_s;
    logic [7:0] len_r, len_s, exp_r, exp_s;
    logic [7:0] bad_addr_r, bad_addr_s, bad_byte_r, bad_byte_s;
    logic       pass_r, pass_s, fail_r, fail_s, proto_r, proto_s;
    logic       halt_r, halt_s, busy_r, busy_s;
    logic       in_range_s;

    pt_range_cmp #(.LO(CH_LO), .HI(CH_HI)) u_range (
        .data     (pt_wrdata),
        .in_range (in_range_s)
    );

    // Next-state, verdict and capture logic; start overrides any same-cycle write.
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        exp_s      = exp_r;
        pass_s     = pass_r;
        fail_s     = fail_r;
        proto_s    = proto_r;
        bad_addr_s = bad_addr_r;
        bad_byte_s = bad_byte_r;
        halt_s     = 1'b0;
        if (start) begin
            state_s    = LEN;
            pass_s     = 1'b0;
            fail_s     = 1'b0;
            proto_s    = 1'b0;
            bad_addr_s = 8'd0;
            bad_byte_s = 8'd0;
        end else if (pt_wren) begin
            case (state_r)
                LEN: begin
                    if (pt_addr == PT_LEN_ADDR) begin
                        len_s = pt_wrdata;
                        exp_s = 8'd1;
                        if (pt_wrdata == 8'd0) begin
                            state_s = PASS;
                            pass_s  = 1'b1;
                        end else begin
                            state_s = CHECK;
                        end
                    end else begin
                        state_s    = FAIL;
                        fail_s     = 1'b1;
                        proto_s    = 1'b1;
                        halt_s     = 1'b1;
                        bad_addr_s = pt_addr;
                        bad_byte_s = pt_wrdata;
                    end
                end
                CHECK: begin
                    if ((pt_addr != exp_r) || !in_range_s) begin
                        state_s    = FAIL;
                        fail_s     = 1'b1;
                        proto_s    = (pt_addr != exp_r);
                        halt_s     = 1'b1;
                        bad_addr_s = pt_addr;
                        bad_byte_s = pt_wrdata;
                    end else if (exp_r == len_r) begin
                        state_s = PASS;
                        pass_s  = 1'b1;
                    end else begin
                        exp_s = exp_r + 8'd1;
                    end
                end
                IDLE, PASS, FAIL: state_s = state_r;
                default:          state_s = IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
        busy_s = (state_s == LEN) || (state_s == CHECK);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            len_r      <= 8'd0;
            exp_r      <= 8'd0;
            pass_r     <= 1'b0;
            fail_r     <= 1'b0;
            proto_r    <= 1'b0;
            bad_addr_r <= 8'd0;
            bad_byte_r <= 8'd0;
            halt_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            len_r      <= len_s;
            exp_r      <= exp_s;
            pass_r     <= pass_s;
            fail_r     <= fail_s;
            proto_r    <= proto_s;
            bad_addr_r <= bad_addr_s;
            bad_byte_r <= bad_byte_s;
            halt_r     <= halt_s;
            busy_r     <= busy_s;
        end
    end

    assign halt      = halt_r;
    assign busy      = busy_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign proto_err = proto_r;
    assign bad_addr  = bad_addr_r;
    assign bad_byte  = bad_byte_r;

`ifdef PT_CHECK_STATS_EN
    logic [15:0] attempts_r, passes_r;

    // Statistics counters; cleared only by rst, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            attempts_r <= 16'd0;
            passes_r   <= 16'd0;
        end else begin
            if (start) begin
                attempts_r <= sat_inc16(attempts_r);
            end
            if ((state_s == PASS) && (state_r != PASS)) begin
                passes_r <= sat_inc16(passes_r);
            end
        end
    end

    assign attempts = attempts_r;
    assign passes   = passes_r;
`endif

endmodule

// File: tb/tb_pt_check.sv
// Scoreboard bench for pt_check: a reference model pushes expected outputs per
// driven cycle, popped and compared one cycle later; plus directed checks.
module tb_pt_check;

    logic       clk = 1'b0;
    logic       rst, start, pt_wren;
    logic [7:0] pt_addr, pt_wrdata;
    logic       halt, busy, pass, fail, proto_err;
    logic [7:0] bad_addr, bad_byte;
    logic       halt2, busy2, pass2, fail2, proto2;
    logic [7:0] bad_addr2, bad_byte2;
`ifdef PT_CHECK_STATS_EN
    logic [15:0] attempts, passes, attempts2, passes2;
`endif

    always #5 clk = ~clk;

    pt_check dut (
        .clk(clk), .rst(rst), .start(start), .pt_addr(pt_addr),
        .pt_wrdata(pt_wrdata), .pt_wren(pt_wren), .halt(halt), .busy(busy),
        .pass(pass), .fail(fail), .proto_err(proto_err), .bad_addr(bad_addr),
`ifdef PT_CHECK_STATS_EN
        .attempts(attempts), .passes(passes),
`endif
        .bad_byte(bad_byte)
    );

    pt_check #(.CH_LO(8'h20), .CH_HI(8'h7D)) dut2 (
        .clk(clk), .rst(rst), .start(start), .pt_addr(pt_addr),
        .pt_wrdata(pt_wrdata), .pt_wren(pt_wren), .halt(halt2), .busy(busy2),
        .pass(pass2), .fail(fail2), .proto_err(proto2), .bad_addr(bad_addr2),
`ifdef PT_CHECK_STATS_EN
        .attempts(attempts2), .passes(passes2),
`endif
        .bad_byte(bad_byte2)
    );

    typedef struct packed {
        logic       halt, busy, pass, fail, proto;
        logic [7:0] ba, bb;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;
    int halt_cnt = 0;

    // reference model state: 0 idle, 1 len, 2 check, 3 pass, 4 fail
    int         m_st = 0;
    logic [7:0] m_len = 8'd0, m_exp = 8'd0, m_ba = 8'd0, m_bb = 8'd0;
    logic       m_pass = 1'b0, m_fail = 1'b0, m_proto = 1'b0, m_halt = 1'b0;
    int         m_att = 0, m_pas = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_fail(input logic [7:0] a, input logic [7:0] d, input logic p);
        m_st = 4; m_fail = 1'b1; m_proto = p; m_ba = a; m_bb = d; m_halt = 1'b1;
    endtask

    task automatic model_step(input logic r, input logic s, input logic w,
                              input logic [7:0] a, input logic [7:0] d);
        m_halt = 1'b0;
        if (r) begin
            m_st = 0; m_len = 8'd0; m_exp = 8'd0; m_ba = 8'd0; m_bb = 8'd0;
            m_pass = 1'b0; m_fail = 1'b0; m_proto = 1'b0; m_att = 0; m_pas = 0;
        end else if (s) begin
            m_st = 1; m_pass = 1'b0; m_fail = 1'b0; m_proto = 1'b0;
            m_ba = 8'd0; m_bb = 8'd0; m_att++;
        end else if (w && m_st == 1) begin
            if (a == 8'd0) begin
                m_len = d; m_exp = 8'd1;
                if (d == 8'd0) begin m_st = 3; m_pass = 1'b1; m_pas++; end
                else m_st = 2;
            end else model_fail(a, d, 1'b1);
        end else if (w && m_st == 2) begin
            if (a != m_exp) model_fail(a, d, 1'b1);
            else if (d < 8'h20 || d > 8'h7E) model_fail(a, d, 1'b0);
            else if (m_exp == m_len) begin m_st = 3; m_pass = 1'b1; m_pas++; end
            else m_exp = m_exp + 8'd1;
        end
    endtask

    // one clock: drive, predict, advance, pop and compare
    task automatic cyc(input logic r, input logic s, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        rst = r; start = s; pt_wren = w; pt_addr = a; pt_wrdata = d;
        model_step(r, s, w, a, d);
        e.halt = m_halt; e.busy = (m_st == 1 || m_st == 2);
        e.pass = m_pass; e.fail = m_fail; e.proto = m_proto; e.ba = m_ba; e.bb = m_bb;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("halt", {31'd0, halt}, {31'd0, e.halt});
        check_eq("busy", {31'd0, busy}, {31'd0, e.busy});
        check_eq("pass", {31'd0, pass}, {31'd0, e.pass});
        check_eq("fail", {31'd0, fail}, {31'd0, e.fail});
        check_eq("proto_err", {31'd0, proto_err}, {31'd0, e.proto});
        check_eq("bad_addr", {24'd0, bad_addr}, {24'd0, e.ba});
        check_eq("bad_byte", {24'd0, bad_byte}, {24'd0, e.bb});
        if (halt) halt_cnt++;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d); cyc(1'b0, 1'b0, 1'b1, a, d); endtask
    task automatic st();   cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0); endtask
    task automatic idle(); cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0); endtask
    task automatic rs();   cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0); endtask

    initial begin
        logic [7:0] dv;
        rs(); rs();
        check_eq("reset_pass", {31'd0, pass}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);

        // printable 3-char text
        halt_cnt = 0;
        st(); wr(8'd0, 8'd3); wr(8'd1, 8'h48); wr(8'd2, 8'h69); wr(8'd3, 8'h21);
        check_eq("s1_pass", {31'd0, pass}, 32'd1);
        idle(); wr(8'd7, 8'h00);
        check_eq("s1_halt_cnt", halt_cnt, 32'd0);

        // bad byte at addr 2; later write ignored
        halt_cnt = 0;
        st(); wr(8'd0, 8'd4); wr(8'd1, 8'h41); wr(8'd2, 8'h07);
        check_eq("s2_fail", {31'd0, fail}, 32'd1);
        check_eq("s2_bad_addr", {24'd0, bad_addr}, 32'd2);
        check_eq("s2_bad_byte", {24'd0, bad_byte}, 32'h07);
        idle(); wr(8'd3, 8'h41); idle();
        check_eq("s2_halt_cnt", halt_cnt, 32'd1);

        // zero length
        st(); wr(8'd0, 8'd0);
        check_eq("s3_pass", {31'd0, pass}, 32'd1);
        check_eq("s3_busy", {31'd0, busy}, 32'd0);

        // skipped address, with an ignored wren=0 cycle in between
        st(); wr(8'd0, 8'd5); cyc(1'b0, 1'b0, 1'b0, 8'd9, 8'h00); wr(8'd1, 8'h41); wr(8'd3, 8'h41);
        check_eq("s4_proto", {31'd0, proto_err}, 32'd1);
        check_eq("s4_bad_addr", {24'd0, bad_addr}, 32'd3);

        // restart mid-check with a colliding write, then 0x7E on both ranges
        st(); wr(8'd0, 8'd9); wr(8'd1, 8'h41);
        cyc(1'b0, 1'b1, 1'b1, 8'd2, 8'h41);
        wr(8'd0, 8'd1); wr(8'd1, 8'h7E);
        check_eq("s5_pass", {31'd0, pass}, 32'd1);
        check_eq("s5_hi7d_fail", {31'd0, fail2}, 32'd1);
        check_eq("s5_hi7d_byte", {24'd0, bad_byte2}, 32'h7E);
        check_eq("s5_hi7d_pass", {31'd0, pass2}, 32'd0);

        // range edges just outside
        st(); wr(8'd0, 8'd2); wr(8'd1, 8'h20); wr(8'd2, 8'h1F);
        st(); wr(8'd0, 8'd2); wr(8'd1, 8'h7F);
        check_eq("s7_fail_7f", {31'd0, fail}, 32'd1);
        // length write to wrong address
        st(); wr(8'd1, 8'd3);

        // maximum length, no wrap
        st(); wr(8'd0, 8'd255);
        for (int i = 1; i <= 255; i++) begin
            dv = 8'(8'h20 + (i % 95));
            wr(8'(i), dv);
        end
        check_eq("l255_pass", {31'd0, pass}, 32'd1);

        // reset mid-check: no halt
        halt_cnt = 0;
        st(); wr(8'd0, 8'd3); wr(8'd1, 8'h41); rs(); wr(8'd2, 8'h00); idle();
        check_eq("rst_mid_halt", halt_cnt, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);

`ifdef PT_CHECK_STATS_EN
        st(); wr(8'd0, 8'd1); wr(8'd1, 8'h41);
        st(); wr(8'd0, 8'd0);
        st(); wr(8'd0, 8'd1); wr(8'd1, 8'h00);
        check_eq("attempts", {16'd0, attempts}, 32'd3);
        check_eq("passes", {16'd0, passes}, 32'd2);
        rs();
        check_eq("attempts_rst", {16'd0, attempts}, 32'd0);
        check_eq("passes_rst", {16'd0, passes}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
